// File: rtl/dividend_reconstruct_seq.sv
// Radix-2 shift-add reconstructor: result = quotient*divisor + remainder, one quotient bit per clock.
// Optional macro RECON_CHECK_EN adds chk_err (divisor==0 or remainder>=divisor at accept).
module dividend_reconstruct_seq #(
    parameter int N = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   quotient,
    input  logic [N-1:0]   divisor,
    input  logic [N-1:0]   remainder,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] result,
`ifdef RECON_CHECK_EN
    output logic           chk_err,
`endif
    output logic           ovf
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_reg, state_next;
    logic [2*N-1:0] acc_reg;
    logic [2*N-1:0] mcand_reg;
    logic [N-1:0]   mplr_reg;
    logic [CW-1:0]  cnt_reg;
    logic [2*N-1:0] result_reg;
    logic           ovf_reg;
    logic [2*N-1:0] acc_sum;
    logic           last_step;

    assign acc_sum   = acc_reg + (mplr_reg[0] ? mcand_reg : '0);
    assign last_step = (cnt_reg == CW'(N - 1));
    assign result    = result_reg;
    assign ovf       = ovf_reg;

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last_step) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

`ifdef RECON_CHECK_EN
    logic [N-1:0] rem_cap_reg;
    logic         dz_reg;
    logic         chk_err_reg;

    assign chk_err = chk_err_reg;

    // On the final step mcand still holds divisor << (N-1), so its window recovers the divisor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_cap_reg <= '0;
            dz_reg      <= 1'b0;
            chk_err_reg <= 1'b0;
        end else if (state_reg == IDLE && in_valid) begin
            rem_cap_reg <= remainder;
            dz_reg      <= (divisor == '0);
        end else if (state_reg == RUN && last_step) begin
            chk_err_reg <= dz_reg || (rem_cap_reg >= mcand_reg[2*N-2:N-1]);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplr_reg   <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        acc_reg   <= {{N{1'b0}}, remainder};
                        mcand_reg <= {{N{1'b0}}, divisor};
                        mplr_reg  <= quotient;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    acc_reg   <= acc_sum;
                    mcand_reg <= mcand_reg << 1;
                    mplr_reg  <= mplr_reg >> 1;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (last_step) begin
                        result_reg <= acc_sum;
                        ovf_reg    <= |acc_sum[2*N-1:N];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dividend_reconstruct_seq.sv
// Directed and randomised bench for dividend_reconstruct_seq (N=24).
// Covers latency, boundary operands, backpressure, asynchronous abort and the optional chk_err output.
module tb_dividend_reconstruct_seq;
    localparam int N = 24;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   quotient, divisor, remainder;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] result;
    logic           ovf;
`ifdef RECON_CHECK_EN
    logic           chk_err;
`endif

    int errors = 0;
    int checks = 0;

    dividend_reconstruct_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quotient  (quotient),
        .divisor   (divisor),
        .remainder (remainder),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
`ifdef RECON_CHECK_EN
        .chk_err   (chk_err),
`endif
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; entered and left #1 after a rising edge.
    task automatic run_op(input string tag, input logic [N-1:0] q, input logic [N-1:0] d,
                          input logic [N-1:0] r, input int gap, input bit hold);
        int lat;
        logic [63:0] exp;
        exp = 64'(q) * 64'(d) + 64'(r);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; quotient = q; divisor = d; remainder = r; out_ready = hold;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        quotient  = N'($urandom); divisor = N'($urandom); remainder = N'($urandom);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'd24);
        check({tag, ".result"}, 64'(result), exp);
        check({tag, ".ovf"}, 64'(ovf), 64'(exp[47:24] != 0));
`ifdef RECON_CHECK_EN
        check({tag, ".chk_err"}, 64'(chk_err), 64'((d == 0) || (r >= d)));
`endif
        if (!hold) begin
            repeat (gap) begin
                @(posedge clk); #1;
                check({tag, ".held"}, 64'(result), exp);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".out_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, ".idle"}, 64'(in_ready), 64'd1);
        check({tag, ".result_kept"}, 64'(result), exp);
        $display("op %s q=0x%06h d=0x%06h r=0x%06h -> result=0x%012h ovf=%0b lat=%0d",
                 tag, q, d, r, result, ovf, lat);
    endtask

    initial begin
        logic [2*N-1:0] held;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        quotient = '0; divisor = '0; remainder = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.result", 64'(result), 64'd0);
        check("rst.ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("basic", 24'd16, 24'h078000, 24'h061000, 0, 1'b1);
        check("basic.value", 64'(result), 64'h7E1000);
        run_op("ones", 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 2, 1'b0);
        check("ones.value", 64'(result), 64'hFFFFFF000000);
        run_op("q0", 24'd0, 24'h123456, 24'h000042, 0, 1'b0);
        check("q0.value", 64'(result), 64'h42);
        run_op("d0", 24'h00ABCD, 24'd0, 24'h000777, 1, 1'b0);
        check("d0.value", 64'(result), 64'h777);

        // Backpressure: result held, new operands ignored while DONE.
        in_valid = 1'b1; quotient = 24'd9; divisor = 24'd9; remainder = 24'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        check("bp.out_valid", 64'(out_valid), 64'd1);
        held = result;
        check("bp.value", 64'(held), 64'd82);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; quotient = 24'd5; divisor = 24'd5; remainder = 24'd0;
            @(posedge clk); #1;
            check("bp.result_stable", 64'(result), 64'd82);
            check("bp.ovf_stable", 64'(ovf), 64'd0);
            check("bp.in_ready_low", 64'(in_ready), 64'd0);
            check("bp.out_valid_high", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp.release_idle", 64'(in_ready), 64'd1);
        check("bp.release_valid", 64'(out_valid), 64'd0);
        $display("op bp held result=0x%012h through 10 stalled cycles", held);
        run_op("after_bp", 24'd5, 24'd5, 24'd0, 0, 1'b0);
        check("after_bp.value", 64'(result), 64'd25);

        // Asynchronous abort mid-RUN.
        in_valid = 1'b1; quotient = 24'hFFFFFF; divisor = 24'hFFFFFF; remainder = 24'hFFFFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort.out_valid", 64'(out_valid), 64'd0);
        check("abort.result", 64'(result), 64'd0);
        check("abort.ovf", 64'(ovf), 64'd0);
        check("abort.in_ready", 64'(in_ready), 64'd1);
        $display("op abort asserted at RUN cycle 12");
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op("after_abort", 24'd3, 24'd7, 24'd2, 0, 1'b0);
        check("after_abort.value", 64'(result), 64'd23);

        // Random back-to-back with random consumer stalls.
        for (int i = 0; i < 20; i++) begin
            run_op($sformatf("rnd%0d", i), N'($urandom), N'($urandom), N'($urandom),
                   int'($urandom_range(0, 3)), 1'b0);
        end

`ifdef RECON_CHECK_EN
        run_op("chk_d0r0", 24'd7, 24'd0, 24'd0, 0, 1'b0);
        check("chk_d0r0.flag", 64'(chk_err), 64'd1);
        run_op("chk_eq", 24'd7, 24'd10, 24'd10, 0, 1'b0);
        check("chk_eq.flag", 64'(chk_err), 64'd1);
        run_op("chk_lt", 24'd7, 24'd10, 24'd9, 0, 1'b0);
        check("chk_lt.flag", 64'(chk_err), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
